// File: rtl/alu_shift_add_multiplier.sv
// Iterative 32x32 unsigned shift-add multiplier that borrows an external
// combinational ALU as its only adder; one partial-product step per clock.
module alu_shift_add_multiplier #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ADD_CMD = 3'd0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  output logic [2:0]           alu_command,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [5:0]       count_q, count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    acc_hi_d     = acc_hi_q;
    acc_lo_d     = acc_lo_q;
    count_d      = count_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    product      = '0;
    alu_operandA = '0;
    alu_operandB = '0;
    alu_command  = ADD_CMD;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d  = multiplicand;
          acc_hi_d = '0;
          acc_lo_d = multiplier;
          count_d  = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        alu_operandA = acc_hi_q;
        alu_operandB = mcand_q;
        // The ALU carry becomes the new accumulator MSB as the pair shifts right.
        if (acc_lo_q[0]) begin
          {acc_hi_d, acc_lo_d} = {alu_carryout, alu_result, acc_lo_q[WIDTH-1:1]};
        end else begin
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 6'd1;
        if (count_q == 6'd31) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        product   = {acc_hi_q, acc_lo_q};
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_shift_add_multiplier.sv
// Randomised bench for the shift-add multiplier: a behavioural ALU feeds the
// DUT and every product is compared with a plain 64-bit multiply.
module tb_alu_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout;

  int checks = 0;
  int errors = 0;

  alu_shift_add_multiplier #(.WIDTH(32), .ADD_CMD(3'd0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_command  (alu_command),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU: only the add command matters here.
  always_comb begin
    if (alu_command == 3'd0) begin
      {alu_carryout, alu_result} = {1'b0, alu_operandA} + {1'b0, alu_operandB};
    end else begin
      {alu_carryout, alu_result} = 33'd0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: quiet inputs after accept; 1: in_valid held high with new operands;
  // 2: random in_valid/out_ready/operands while busy.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                       input int stall, input int mode);
    logic [63:0] exp;
    int lat;
    int w;
    exp = 64'(m) * 64'(q);
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = (mode == 1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("run_cmd", 64'(alu_command), 64'd0);
      chk("run_opB", 64'(alu_operandB), 64'(m));
      chk("run_in_ready", 64'(in_ready), 64'd0);
      multiplicand = $urandom;
      multiplier   = $urandom;
      if (mode == 2) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd33);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_product", product, exp);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      multiplicand = $urandom;
      multiplier   = $urandom;
      if (mode == 2) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("product", product, exp);
    chk("done_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_opA", 64'(alu_operandA), 64'd0);
    chk("rst_cmd", 64'(alu_command), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of an operation.
    multiplicand = 32'hCAFEBABE;
    multiplier   = 32'h87654321;
    in_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun_busy", 64'(in_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_opA", 64'(alu_operandA), 64'd0);
    chk("midrst_opB", 64'(alu_operandB), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    do_op(32'd7, 32'd9, 0, 0);

    // Directed corners.
    do_op(32'd3, 32'd5, 0, 0);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    do_op(32'd0, 32'hDEADBEEF, 0, 0);
    do_op(32'h12345678, 32'd1, 0, 0);
    do_op(32'h80000000, 32'h80000000, 2, 2);
    do_op(32'hABCDEF01, 32'h13579BDF, 10, 1);
    do_op(32'd11, 32'd13, 0, 0);

    // Random pairs with random stalls and noise on the inputs.
    for (int n = 0; n < 1000; n++) begin
      do_op($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
